// File: rtl/pkt_handler.sv
// Vehicle-node packet receiver: collects 4-byte frames, filters on vehicle ID,
// delivers DATA payloads and latches a sticky KILL command.
module pkt_handler #(
    parameter logic [7:0] BCAST_ID     = 8'hFF,
    parameter logic [7:0] OP_DATA      = 8'h00,
    parameter logic [7:0] OP_KILL      = 8'hFF,
    parameter int         IDLE_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  veh_id,
    input  logic [7:0]  rx_frame,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [15:0] data,
    output logic        data_valid,
    output logic        kill
);

    typedef enum logic [2:0] {
        S_B0,
        S_B1,
        S_B2,
        S_B3,
        S_PROC
    } state_t;

    localparam int CW = $clog2(IDLE_TIMEOUT + 1);

    state_t        state;
    state_t        next_state;
    logic [CW-1:0] idle_cnt;
    logic [7:0]    dest;
    logic [7:0]    opcode;
    logic [7:0]    pay_hi;
    logic [7:0]    pay_lo;
    logic          accept;
    logic          in_frame;
    logic          timeout_hit;
    logic          addr_match;

    assign accept      = rx_valid & rx_ready;
    assign in_frame    = (state == S_B1) || (state == S_B2) || (state == S_B3);
    assign timeout_hit = in_frame && !accept &&
                         (idle_cnt == CW'(IDLE_TIMEOUT - 1));
    assign addr_match  = (dest == veh_id) || (dest == BCAST_ID);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_B0;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            S_B0: if (accept) next_state = S_B1;
            S_B1: begin
                if (accept)           next_state = S_B2;
                else if (timeout_hit) next_state = S_B0;
            end
            S_B2: begin
                if (accept)           next_state = S_B3;
                else if (timeout_hit) next_state = S_B0;
            end
            S_B3: begin
                if (accept)           next_state = S_PROC;
                else if (timeout_hit) next_state = S_B0;
            end
            S_PROC:  next_state = S_B0;
            default: next_state = S_B0;
        endcase
    end

    // Ready is registered so the PROC cycle is a single guaranteed stall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_ready <= 1'b0;
            idle_cnt <= '0;
        end else begin
            rx_ready <= (next_state != S_PROC);
            if (accept || !in_frame || timeout_hit) begin
                idle_cnt <= '0;
            end else begin
                idle_cnt <= idle_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dest   <= 8'h00;
            opcode <= 8'h00;
            pay_hi <= 8'h00;
            pay_lo <= 8'h00;
        end else if (accept) begin
            unique case (state)
                S_B0:    dest   <= rx_frame;
                S_B1:    opcode <= rx_frame;
                S_B2:    pay_hi <= rx_frame;
                S_B3:    pay_lo <= rx_frame;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data       <= 16'h0000;
            data_valid <= 1'b0;
            kill       <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            if (state == S_PROC && addr_match) begin
                if (opcode == OP_DATA && !kill) begin
                    data       <= {pay_hi, pay_lo};
                    data_valid <= 1'b1;
                end else if (opcode == OP_KILL) begin
                    kill <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_pkt_handler.sv
// Directed bench for pkt_handler: stimulus pushes expected payloads into a
// queue, a negedge monitor pops and compares on every data_valid pulse.
module tb_pkt_handler;

    logic        clk;
    logic        rst;
    logic [7:0]  veh_id;
    logic [7:0]  rx_frame;
    logic        rx_valid;
    logic        rx_ready;
    logic [15:0] data;
    logic        data_valid;
    logic        kill;

    int checks;
    int failures;
    logic [15:0] exp_q[$];
    logic        dv_prev;

    pkt_handler dut (
        .clk       (clk),
        .rst       (rst),
        .veh_id    (veh_id),
        .rx_frame  (rx_frame),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .data      (data),
        .data_valid(data_valid),
        .kill      (kill)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Monitor: every data_valid pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (rst) begin
            dv_prev = 1'b0;
        end else begin
            if (data_valid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_dv: data=%h with nothing expected", data);
                end else begin
                    logic [15:0] e;
                    e = exp_q.pop_front();
                    checks++;
                    if (data !== e) begin
                        failures++;
                        $display("FAIL dv_data: got %h expected %h", data, e);
                    end
                end
                checks++;
                if (dv_prev) begin
                    failures++;
                    $display("FAIL dv_width: got 2+ cycles expected 1");
                end
            end
            dv_prev = data_valid;
        end
    end

    // Called just after a negedge; returns just after the negedge following accept.
    task automatic send_byte(input logic [7:0] b);
        int t;
        logic acc;
        t = 0;
        rx_frame = b;
        rx_valid = 1'b1;
        forever begin
            acc = rx_ready;
            @(posedge clk);
            @(negedge clk);
            if (acc) break;
            t++;
            if (t > 50) begin
                checks++;
                failures++;
                $display("FAIL accept_timeout: byte %h not accepted", b);
                break;
            end
        end
    endtask

    task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1,
                              input logic [7:0] b2, input logic [7:0] b3);
        send_byte(b0);
        send_byte(b1);
        send_byte(b2);
        send_byte(b3);
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        rx_valid = 1'b0;
        idle(2);
        rst = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        dv_prev  = 1'b0;
        veh_id   = 8'h01;
        rx_frame = 8'h00;
        rx_valid = 1'b0;
        rst      = 1'b1;

        // 1: reset values, rx_ready rises one edge after release
        idle(2);
        chk("rst_ready", {31'd0, rx_ready}, 32'd0);
        chk("rst_data", {16'd0, data}, 32'h0000);
        chk("rst_dv", {31'd0, data_valid}, 32'd0);
        chk("rst_kill", {31'd0, kill}, 32'd0);
        rst = 1'b0;
        #1;
        chk("rel_ready_before_edge", {31'd0, rx_ready}, 32'd0);
        @(negedge clk);
        chk("rel_ready_after_edge", {31'd0, rx_ready}, 32'd1);

        // 2: broadcast kill, kill appears two edges after last byte
        send_frame(8'hFF, 8'hFF, 8'hFF, 8'hFF);
        chk("kill_one_edge", {31'd0, kill}, 32'd0);
        chk("proc_stall", {31'd0, rx_ready}, 32'd0);
        idle(1);
        chk("kill_two_edges", {31'd0, kill}, 32'd1);
        chk("ready_back", {31'd0, rx_ready}, 32'd1);
        idle(3);
        chk("kill_sticky", {31'd0, kill}, 32'd1);
        chk("kill_data_hold", {16'd0, data}, 32'h0000);

        // 3: addressed DATA frame after reset
        do_reset();
        idle(1);
        chk("kill_cleared", {31'd0, kill}, 32'd0);
        exp_q.push_back(16'h9673);
        send_frame(8'h01, 8'h00, 8'h96, 8'h73);
        chk("dv_low_in_proc", {31'd0, data_valid}, 32'd0);
        idle(1);
        chk("dv_pulse", {31'd0, data_valid}, 32'd1);
        idle(1);
        chk("dv_drop", {31'd0, data_valid}, 32'd0);
        chk("data_9673", {16'd0, data}, 32'h9673);
        chk("no_kill_3", {31'd0, kill}, 32'd0);

        // 4: foreign ID dropped, broadcast DATA delivered
        send_frame(8'h02, 8'h00, 8'h12, 8'h34);
        idle(3);
        chk("foreign_hold", {16'd0, data}, 32'h9673);
        exp_q.push_back(16'hABCD);
        send_frame(8'hFF, 8'h00, 8'hAB, 8'hCD);
        idle(2);
        chk("bcast_data", {16'd0, data}, 32'hABCD);
        // unknown opcode: no change
        send_frame(8'h01, 8'h42, 8'h11, 8'h22);
        idle(3);
        chk("badop_hold", {16'd0, data}, 32'hABCD);
        chk("badop_nokill", {31'd0, kill}, 32'd0);

        // 5: partial frame discarded after 16 idle cycles
        send_byte(8'h01);
        send_byte(8'h00);
        rx_valid = 1'b0;
        idle(16);
        exp_q.push_back(16'h55AA);
        send_frame(8'h01, 8'h00, 8'h55, 8'hAA);
        idle(3);
        chk("timeout_data", {16'd0, data}, 32'h55AA);

        // 6: after kill frames still consume with stall, no data
        send_frame(8'h01, 8'hFF, 8'h00, 8'h00);
        idle(2);
        chk("kill_set_6", {31'd0, kill}, 32'd1);
        send_frame(8'h01, 8'h00, 8'h96, 8'h73);
        chk("stall_6", {31'd0, rx_ready}, 32'd0);
        idle(1);
        chk("ready_6", {31'd0, rx_ready}, 32'd1);
        chk("nodv_6", {31'd0, data_valid}, 32'd0);
        idle(2);
        chk("data_hold_6", {16'd0, data}, 32'h55AA);
        do_reset();
        #1;
        chk("rst_kill_6", {31'd0, kill}, 32'd0);
        chk("rst_data_6", {16'd0, data}, 32'h0000);

        idle(3);
        chk("queue_empty", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
